// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the system-bus memory sequencer.
package mem_seq_pkg;

  localparam int unsigned WORD_W_DFLT = 10;
  localparam int unsigned OP_W_DFLT   = 3;

  function automatic int unsigned addr_width(input int unsigned word_w, input int unsigned op_w);
    return word_w - op_w;
  endfunction

  localparam int unsigned ADDR_W = addr_width(WORD_W_DFLT, OP_W_DFLT);

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRd,
    StWr,
    StAck
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: registered priority pointer, combinational winner.
module rr_arbiter2
  import mem_seq_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       any_o,
  output logic       winner_o
);

  // Requester favoured on a tie; reset favours the CPU.
  logic prio_q, prio_d;

  always_comb begin
    any_o    = |req_i;
    winner_o = (req_i == 2'b11) ? prio_q : req_i[GNT_LD];
    prio_d   = prio_q;
    if (take_i && any_o) begin
      prio_d = ~winner_o;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prio_q <= GNT_CPU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Shares the system-bus memory between the CPU and the character loader,
// sequencing MAR/MDR strobes for one fixed-length transaction at a time.
module mem_bus_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 10,
  parameter int unsigned OP_W   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [WORD_W-OP_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0]      cpu_wdata,
  output logic                   cpu_ack,
  output logic [WORD_W-1:0]      cpu_rdata,
  input  logic                   ld_req,
  input  logic                   ld_we,
  input  logic [WORD_W-OP_W-1:0] ld_addr,
  input  logic [WORD_W-1:0]      ld_wdata,
  output logic                   ld_ack,
  output logic [WORD_W-1:0]      ld_rdata,
  output logic [WORD_W-1:0]      bus_out,
  output logic                   bus_oe,
  input  logic [WORD_W-1:0]      bus_in,
  output logic                   load_MAR,
  output logic                   load_MDR,
  output logic                   MDR_bus,
  output logic                   CS,
  output logic                   R_NW,
  output logic                   grant
);

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    we_q, we_d;
  logic [WORD_W-OP_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic [WORD_W-1:0]       cpu_rdata_q, ld_rdata_q;
  logic                    arb_any, arb_winner;

  rr_arbiter2 u_arb (
    .clock_i  (clock),
    .reset_i  (reset),
    .req_i    ({ld_req, cpu_req}),
    .take_i   (state_q == StIdle),
    .any_o    (arb_any),
    .winner_o (arb_winner)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bus_out  = '0;
    bus_oe   = 1'b0;
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    MDR_bus  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    cpu_ack  = 1'b0;
    ld_ack   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_d = arb_winner;
          if (arb_winner == GNT_LD) begin
            we_d    = ld_we;
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          state_d = StAddr;
        end
      end
      StAddr: begin
        bus_oe   = 1'b1;
        bus_out  = {{OP_W{1'b0}}, addr_q};
        load_MAR = 1'b1;
        CS       = 1'b1;
        state_d  = we_q ? StWr : StRd;
      end
      StRd: begin
        // Bus released so memory MDR can drive the read word.
        MDR_bus = 1'b1;
        CS      = 1'b1;
        R_NW    = 1'b1;
        state_d = StAck;
      end
      StWr: begin
        bus_oe   = 1'b1;
        bus_out  = wdata_q;
        load_MDR = 1'b1;
        CS       = 1'b1;
        state_d  = StAck;
      end
      StAck: begin
        cpu_ack = (grant_q == GNT_CPU);
        ld_ack  = (grant_q == GNT_LD);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= GNT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else if (state_q == StRd) begin
      if (grant_q == GNT_CPU) begin
        cpu_rdata_q <= bus_in;
      end else begin
        ld_rdata_q <= bus_in;
      end
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer with a small MAR/MDR memory model.
module tb_mem_bus_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [6:0] cpu_addr = '0;
  logic [9:0] cpu_wdata = '0;
  logic       cpu_ack;
  logic [9:0] cpu_rdata;
  logic       ld_req = 1'b0, ld_we = 1'b0;
  logic [6:0] ld_addr = '0;
  logic [9:0] ld_wdata = '0;
  logic       ld_ack;
  logic [9:0] ld_rdata;
  logic [9:0] bus_out, bus_in;
  logic       bus_oe, load_MAR, load_MDR, MDR_bus, CS, R_NW, grant;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] mem [128];
  logic [6:0] mar_q = '0;

  always #5 clock = ~clock;

  mem_bus_sequencer #(.WORD_W(10), .OP_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in),
    .load_MAR  (load_MAR),
    .load_MDR  (load_MDR),
    .MDR_bus   (MDR_bus),
    .CS        (CS),
    .R_NW      (R_NW),
    .grant     (grant)
  );

  // Memory: MAR loads from the bus, MDR output is combinational from MAR.
  always @(posedge clock) begin
    if (load_MAR) mar_q <= bus_out[6:0];
    if (load_MDR) mem[mar_q] <= bus_out;
  end
  assign bus_in = mem[mar_q];

  always @(negedge clock) begin
    if (!reset) begin
      n_tests++;
      assert (!(bus_oe && MDR_bus) && !(cpu_ack && ld_ack)) else begin
        n_fail++;
        $error("FAIL exclusivity: oe=%0b mdr_bus=%0b cpu_ack=%0b ld_ack=%0b",
               bus_oe, MDR_bus, cpu_ack, ld_ack);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [16:0] cpu_seen, ld_seen;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[5] = 10'h2A3;

    // Reset state
    step();
    step();
    chk("rst_strobes", {27'b0, load_MAR, load_MDR, MDR_bus, CS, R_NW}, 32'h0);
    chk("rst_oe_grant", {29'b0, bus_oe, grant, cpu_ack | ld_ack}, 32'h0);
    chk("rst_bus_out", bus_out, 32'h0);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, 32'h0);

    // CPU read of addr 5
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd5;
    step();
    chk("rd_addr_bus", bus_out, 32'h005);
    chk("rd_addr_strb", {28'b0, bus_oe, load_MAR, CS, grant}, 32'hE);
    step();
    chk("rd_rd_strb", {28'b0, MDR_bus, R_NW, CS, bus_oe}, 32'hE);
    step();
    chk("rd_ack", {30'b0, cpu_ack, ld_ack}, 32'h2);
    chk("rd_rdata", cpu_rdata, 32'h2A3);
    chk("rd_ld_rdata", ld_rdata, 32'h0);
    cpu_req = 1'b0;
    step();
    chk("rd_idle_ack", {30'b0, cpu_ack, ld_ack}, 32'h0);

    // Loader write 0x041 to addr 71
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 7'd71; ld_wdata = 10'h041;
    step();
    chk("wr_addr_bus", bus_out, 32'h047);
    chk("wr_grant", grant, 32'h1);
    step();
    chk("wr_bus_out", bus_out, 32'h041);
    chk("wr_strb", {27'b0, load_MDR, R_NW, CS, bus_oe, MDR_bus}, 32'h16);
    step();
    chk("wr_ack", {30'b0, cpu_ack, ld_ack}, 32'h1);
    chk("wr_cpu_rdata", cpu_rdata, 32'h2A3);
    ld_req = 1'b0;
    step();
    chk("wr_mem", mem[71], 32'h041);

    // Both requesting from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd5;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 7'd71;
    cpu_seen = '0; ld_seen = '0;
    for (int i = 1; i <= 16; i++) begin
      step();
      cpu_seen[i] = cpu_ack;
      ld_seen[i]  = ld_ack;
      if (i == 1) chk("rr_first_grant", grant, 32'h0);
      if (i == 5) chk("rr_second_grant", grant, 32'h1);
    end
    chk("rr_cpu_acks", cpu_seen, 32'h00808);
    chk("rr_ld_acks", ld_seen, 32'h08080);
    chk("rr_cpu_rdata", cpu_rdata, 32'h2A3);
    chk("rr_ld_rdata", ld_rdata, 32'h041);
    cpu_req = 1'b0; ld_req = 1'b0;
    step();

    // CPU back-to-back, address change during RD ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd5;
    cpu_seen = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      cpu_seen[i] = cpu_ack;
      if (i == 2) cpu_addr = 7'd71;
      if (i == 3) chk("b2b_rdata1", cpu_rdata, 32'h2A3);
      if (i == 7) begin
        chk("b2b_rdata2", cpu_rdata, 32'h041);
        cpu_req = 1'b0;
      end
    end
    chk("b2b_acks", cpu_seen, 32'h00088);

    // Reset during WR
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'd10; cpu_wdata = 10'h155;
    step();
    step();
    chk("rw_in_wr", {30'b0, load_MDR, CS}, 32'h3);
    reset = 1'b1;
    step();
    chk("rw_strobes", {26'b0, load_MAR, load_MDR, MDR_bus, CS, R_NW, bus_oe}, 32'h0);
    chk("rw_ack", {29'b0, cpu_ack, ld_ack, grant}, 32'h0);
    chk("rw_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    cpu_we = 1'b0; cpu_addr = 7'd5;
    step();
    chk("rs_c1", {30'b0, cpu_ack, load_MAR}, 32'h1);
    step();
    chk("rs_c2", {30'b0, cpu_ack, MDR_bus}, 32'h1);
    step();
    chk("rs_c3", {30'b0, cpu_ack, ld_ack}, 32'h2);
    chk("rs_rdata", cpu_rdata, 32'h2A3);
    cpu_req = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_sequencer.md
# mem_bus_sequencer

Bus sequencer that shares the processor's system-bus memory (ROM program store and RAM character buffers) between two requesters: the CPU datapath and the character loader (switch-input/auto-loader engine). It arbitrates round-robin, then drives the MAR/MDR control strobes and the bus data for one read or write transaction at a time. It sits between the requesters and the top-level `sysbus` tristate, so neither requester toggles `load_MAR`, `MDR_bus`, `CS` or `R_NW` directly.

## Interface
- `WORD_W`, 10, bus/word width
- `OP_W`, 3, opcode field width; address width `ADDR_W = WORD_W-OP_W`
- `clock` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `cpu_req` in 1: CPU transaction request, held until `cpu_ack`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_W: target address
- `cpu_wdata` in WORD_W: write data
- `cpu_ack` out 1: one-cycle completion pulse
- `cpu_rdata` out WORD_W: last read data, registered
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_ack`, `ld_rdata`: loader port, identical semantics
- `bus_out` out WORD_W: value the top level drives onto `sysbus`
- `bus_oe` out 1: tristate enable for `bus_out`
- `bus_in` in WORD_W: `sysbus` readback
- `load_MAR`, `load_MDR`, `MDR_bus`, `CS`, `R_NW` out 1: memory control strobes
- `grant` out 1: owner of the current or last transaction (0 = CPU, 1 = loader)

## Operation
- FSM states: IDLE, ADDR, RD, WR, ACK.
- **IDLE**
  - All strobes are 0.
  - If any request is present, the arbiter picks the winner.
  - The winner's addr/we/wdata are latched into internal registers and `grant` is set.
  - Next state is ADDR.
  - With no request, the FSM stays in IDLE.
- **ADDR**
  - `bus_oe=1`, `bus_out={OP_W'b0, addr}`, `load_MAR=1`, `CS=1`.
  - Next state is WR if `we`, else RD.
- **RD**
  - `MDR_bus=1`, `CS=1`, `R_NW=1`, `bus_oe=0`.
  - `bus_in` is captured at the clock edge into the granted port's rdata register.
  - Next state is ACK.
- **WR**
  - `bus_oe=1`, `bus_out=wdata`, `load_MDR=1`, `CS=1`, `R_NW=0`.
  - Next state is ACK.
- **ACK**
  - The granted port's ack is 1 for this cycle only.
  - Next state is IDLE.
- **Arbitration**
  - Two-way round-robin; the last winner loses a tie.
  - After reset, the CPU has priority on the first tie.
  - A lone requester always wins.
- **Port rules**
  - Request inputs are sampled only in IDLE.
  - Changes to addr/we/wdata after the latch are ignored.
  - A request still high in the cycle after its ack starts a new transaction (back-to-back).
  - The non-granted port's ack and rdata are unchanged throughout.
- **Reset values**
  - All strobes, `bus_oe`, both acks and `grant` are 0.
  - `bus_out`, `cpu_rdata` and `ld_rdata` are 0.
  - State is IDLE; round-robin pointer favours the CPU.
- **Reset mid-transaction**: the FSM aborts to IDLE on the next edge and no ack is issued.
- **Exclusivity**
  - `bus_oe` and `MDR_bus` are never 1 in the same cycle.
  - At most one ack is high in any cycle.

## Timing
- Request seen in IDLE at edge 0:
  - ADDR is cycle 1.
  - RD or WR is cycle 2.
  - ACK is cycle 3; rdata is valid from cycle 3.
- Transaction length is fixed at 4 cycles, including the IDLE arbitration cycle.
- With both ports requesting continuously, grants alternate and each port gets one ack every 8 cycles.
- Worst-case wait from request to start is 4 cycles.
- Memory read data must be valid on `bus_in` in the same cycle that `MDR_bus` is high; the memory MDR output is combinational from MAR.

## Structure
- Package `mem_seq_pkg` holds:
  - the `state_t` enum (IDLE, ADDR, RD, WR, ACK);
  - `ADDR_W` derivation;
  - grant encoding constants `GNT_CPU=0` and `GNT_LD=1`.
- Sub-module `rr_arbiter2` (registered last-grant pointer, combinational winner) is instantiated once.
- The top-level `sysbus` tristate stays outside this block.

## Test plan
- **CPU read ROM addr 7'd5 (word 10'h2A3), no loader traffic**
  - ADDR cycle: `bus_out=10'h005`, `load_MAR=1`.
  - RD cycle: `MDR_bus=1`, `R_NW=1`.
  - `cpu_ack` is high at cycle 3 with `cpu_rdata=10'h2A3`.
- **Loader write 10'h041 to addr 7'd71**
  - WR cycle: `bus_out=10'h041`, `load_MDR=1`, `R_NW=0`, `CS=1`.
  - `ld_ack` is high at cycle 3; `cpu_ack` stays 0.
- **Both requests held high from reset for 16 cycles**
  - Acks alternate CPU, loader, CPU, loader, 8 cycles apart per port.
  - The first grant goes to the CPU.
- **CPU holds `cpu_req` continuously, loader idle**
  - Back-to-back acks every 4 cycles.
  - `cpu_addr` changed during RD does not affect the in-flight access.
- **Reset asserted during the WR cycle**
  - All strobes are 0 on the next edge and no ack is issued.
  - A later CPU request restarts cleanly, with ack 3 cycles after IDLE.
- **Whole run assertion**: `bus_oe & MDR_bus` is never 1, and `cpu_ack & ld_ack` is never 1.
